// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: CPU has absolute priority, the aux requester fills idle slots.
// Optional macro ARB_FORCE_GRANT_EN adds cpu_stall and forces a grant once aux is starved.
module mem_port_arbiter #(
   parameter int AW       = 9,
   parameter int DW       = 16,
   parameter int MAX_WAIT = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    cpu_cmd,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   input  logic          aux_req,
   input  logic          aux_we,
   input  logic [AW-1:0] aux_addr,
   input  logic [DW-1:0] aux_wdata,
   output logic          aux_busy,
   output logic          aux_ack,
   output logic [DW-1:0] aux_rdata,
   output logic          aux_starved,
`ifdef ARB_FORCE_GRANT_EN
   output logic          cpu_stall,
`endif
   output logic [1:0]    mem_cmd,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [1:0] CMD_NONE = 2'b00;
   localparam logic [1:0] CMD_RD   = 2'b01;
   localparam logic [1:0] CMD_WR   = 2'b10;
   localparam logic [7:0] MAXW     = 8'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [7:0]    wait_q, wait_d;
   logic          starved_q;
   logic          cpu_act;
   logic          force_g;
   logic          aux_own;

   assign cpu_act = (cpu_cmd == CMD_RD) || (cpu_cmd == CMD_WR);

`ifdef ARB_FORCE_GRANT_EN
   assign force_g   = (wait_q >= MAXW);
   assign cpu_stall = aux_own && cpu_act;
`else
   assign force_g   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wait_d  = wait_q;
      aux_own = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (aux_req) begin
               we_d    = aux_we;
               addr_d  = aux_addr;
               wdata_d = aux_wdata;
               state_d = PEND;
            end
         end
         PEND: begin
            if (!cpu_act || force_g) begin
               aux_own = 1'b1;
               if (!we_q) rdata_d = mem_rdata;
               state_d = ACK;
            end else if (wait_q != 8'hFF) begin
               wait_d = wait_q + 8'd1;
            end
         end
         ACK: begin
            state_d = IDLE;
            wait_d  = 8'd0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Port mux: the latched aux command only appears in its granted cycle
   always_comb begin
      mem_cmd   = cpu_act ? cpu_cmd : CMD_NONE;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (aux_own) begin
         mem_cmd   = we_q ? CMD_WR : CMD_RD;
         mem_addr  = addr_q;
         mem_wdata = wdata_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         wait_q    <= 8'd0;
         starved_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         wait_q    <= wait_d;
         starved_q <= (wait_d >= MAXW);
      end
   end

   assign cpu_rdata   = mem_rdata;
   assign aux_busy    = (state_q != IDLE);
   assign aux_ack     = (state_q == ACK);
   assign aux_rdata   = rdata_q;
   assign aux_starved = starved_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model plus directed scenarios.
// Works with or without ARB_FORCE_GRANT_EN defined.
module tb_mem_port_arbiter;

   localparam int AW = 9;
   localparam int DW = 16;
   localparam int MW = 3;
`ifdef ARB_FORCE_GRANT_EN
   localparam bit FG = 1'b1;
`else
   localparam bit FG = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [1:0]    cpu_cmd = '0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          aux_req = 1'b0;
   logic          aux_we = 1'b0;
   logic [AW-1:0] aux_addr = '0;
   logic [DW-1:0] aux_wdata = '0;
   logic          aux_busy, aux_ack, aux_starved;
   logic [DW-1:0] aux_rdata;
   logic          cpu_stall;
   logic [1:0]    mem_cmd;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign mem_rdata = mem[mem_addr];

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset),
      .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
      .aux_wdata(aux_wdata), .aux_busy(aux_busy), .aux_ack(aux_ack),
      .aux_rdata(aux_rdata), .aux_starved(aux_starved),
`ifdef ARB_FORCE_GRANT_EN
      .cpu_stall(cpu_stall),
`endif
      .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );
`ifndef ARB_FORCE_GRANT_EN
   assign cpu_stall = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: one outstanding aux transaction, an ack cycle, and a wait count
   bit            m_out, m_ack, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wd, m_rdata;
   int            m_wait;

   function automatic bit cpu_busy_f();
      return (cpu_cmd == 2'b01) || (cpu_cmd == 2'b10);
   endfunction

   function automatic bit grant_f();
      return m_out && (!cpu_busy_f() || (FG && m_wait >= MW));
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_out = 0; m_ack = 0; m_we = 0;
         m_addr = '0; m_wd = '0; m_rdata = '0; m_wait = 0;
      end else if (m_ack) begin
         m_ack = 0;
         m_wait = 0;
      end else if (grant_f()) begin
         if (!m_we) m_rdata = mem[m_addr];
         m_out = 0;
         m_ack = 1;
      end else if (m_out) begin
         if (m_wait < 255) m_wait++;
      end else if (aux_req) begin
         m_out = 1; m_we = aux_we; m_addr = aux_addr; m_wd = aux_wdata;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (grant_f()) begin
            chk("m_cmd", 32'(mem_cmd), m_we ? 32'd2 : 32'd1);
            chk("m_addr", 32'(mem_addr), 32'(m_addr));
            if (m_we) chk("m_wdata", 32'(mem_wdata), 32'(m_wd));
         end else begin
            chk("m_cmd", 32'(mem_cmd), cpu_busy_f() ? 32'(cpu_cmd) : 32'd0);
            chk("m_addr", 32'(mem_addr), 32'(cpu_addr));
            chk("m_wdata", 32'(mem_wdata), 32'(cpu_wdata));
         end
         chk("m_busy", 32'(aux_busy), 32'(m_out || m_ack));
         chk("m_ack", 32'(aux_ack), 32'(m_ack));
         chk("m_rdata", 32'(aux_rdata), 32'(m_rdata));
         chk("m_starved", 32'(aux_starved), 32'(m_wait >= MW));
         chk("m_cpu_rdata", 32'(cpu_rdata), 32'(mem[mem_addr]));
         if (FG) chk("m_stall", 32'(cpu_stall),
                     32'(grant_f() && cpu_busy_f()));
      end
      if (mem_cmd == 2'b10) mem[mem_addr] = mem_wdata;
   end

   task automatic step(input logic [1:0] c, input logic [AW-1:0] ca,
                       input logic r, input logic w,
                       input logic [AW-1:0] aa, input logic [DW-1:0] ad);
      @(posedge clk);
      #1;
      cpu_cmd = c; cpu_addr = ca; cpu_wdata = 16'h5A00 | 16'(ca);
      aux_req = r; aux_we = w; aux_addr = aa; aux_wdata = ad;
      @(negedge clk);
   endtask

   int rd_n, wr_n, ack_n;

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i * 3);
      mem[5] = 16'hBEEF;
      for (int i = 0; i < 9; i++) mem[9'h20 + i] = 16'h1000 + 16'(i);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(aux_busy), 0);
      chk("rst_ack", 32'(aux_ack), 0);
      chk("rst_starved", 32'(aux_starved), 0);
      chk("rst_rdata", 32'(aux_rdata), 0);
      chk("rst_cmd", 32'(mem_cmd), 0);
      mon_en = 1'b1;

      // aux read, CPU idle
      step(2'b00, 9'h0, 1, 0, 9'h05, 16'h0);
      step(2'b00, 9'h0, 0, 0, 9'h0, 16'h0);
      chk("t1_cmd", 32'(mem_cmd), 1);
      chk("t1_addr", 32'(mem_addr), 5);
      step(2'b00, 9'h0, 0, 0, 9'h0, 16'h0);
      chk("t1_ack", 32'(aux_ack), 1);
      chk("t1_rdata", 32'(aux_rdata), 32'hBEEF);
      step(2'b00, 9'h0, 0, 0, 9'h0, 16'h0);
      chk("t1_busy", 32'(aux_busy), 0);

      // aux write behind four CPU reads
      step(2'b00, 9'h0, 1, 1, 9'h10, 16'h1234);
      rd_n = 0; wr_n = 0; ack_n = 0;
      for (int i = 0; i < 7; i++) begin
         step(i < 4 ? 2'b01 : 2'b00, 9'h80 + 9'(i), 0, 0, 9'h0, 16'h0);
         if (mem_cmd == 2'b01) rd_n++;
         if (mem_cmd == 2'b10) wr_n++;
         if (aux_ack) ack_n++;
      end
      chk("t2_reads", 32'(rd_n), FG ? 3 : 4);
      chk("t2_writes", 32'(wr_n), 1);
      chk("t2_acks", 32'(ack_n), 1);
      step(2'b01, 9'h10, 0, 0, 9'h0, 16'h0);
      chk("t2_readback", 32'(cpu_rdata), 32'h1234);

      // starvation with MAX_WAIT=3
      step(2'b00, 9'h0, 1, 1, 9'h30, 16'h0ABC);
      for (int i = 0; i < 5; i++) begin
         step(2'b01, 9'h40 + 9'(i), 0, 0, 9'h0, 16'h0);
         if (i == 2) chk("t3_starved_b3", 32'(aux_starved), 0);
         if (i == 3) begin
            chk("t3_starved_b4", 32'(aux_starved), 1);
            chk("t3_cmd_b4", 32'(mem_cmd), FG ? 2 : 1);
            chk("t3_stall_b4", 32'(cpu_stall), 32'(FG));
         end
      end
      repeat (4) step(2'b00, 9'h0, 0, 0, 9'h0, 16'h0);
      chk("t3_starved_end", 32'(aux_starved), 0);
      chk("t3_busy_end", 32'(aux_busy), 0);
      chk("t3_mem", 32'(mem[9'h30]), 32'h0ABC);

      // asynchronous reset mid-PEND
      step(2'b00, 9'h0, 1, 0, 9'h05, 16'h0);
      step(2'b01, 9'h44, 0, 0, 9'h0, 16'h0);
      step(2'b01, 9'h45, 0, 0, 9'h0, 16'h0);
      chk("t4_busy_pre", 32'(aux_busy), 1);
      #2 reset = 1'b1;
      #1;
      chk("t4_busy", 32'(aux_busy), 0);
      chk("t4_rdata", 32'(aux_rdata), 0);
      chk("t4_cmd", 32'(mem_cmd), 1);
      @(posedge clk);
      #1 reset = 1'b0;
      ack_n = 0;
      for (int i = 0; i < 4; i++) begin
         step(2'b00, 9'h0, 0, 0, 9'h0, 16'h0);
         if (aux_ack) ack_n++;
      end
      chk("t4_no_ack", 32'(ack_n), 0);

      // req held high: one ack every 3 cycles
      ack_n = 0;
      for (int i = 0; i < 9; i++) begin
         step(2'b00, 9'h0, 1, 0, 9'h20 + 9'(i), 16'h0);
         if (aux_ack) ack_n++;
      end
      chk("t5_acks", 32'(ack_n), 3);
      chk("t5_rdata", 32'(aux_rdata), 32'h1006);
      step(2'b00, 9'h0, 0, 0, 9'h0, 16'h0);
      step(2'b11, 9'h07, 0, 0, 9'h0, 16'h0);
      chk("t5_cmd11", 32'(mem_cmd), 0);
      chk("t5_addr11", 32'(mem_addr), 7);

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single memory port between the CPU fetch/load/store path and one auxiliary requester, such as a program loader, debug port or I/O DMA. The CPU's memory command passes straight through with absolute priority. The aux requester uses a latched req/ack handshake and is served in any cycle where the CPU's command is NONE. A wait counter tracks aux starvation.

Parameters:
AW, 9, memory address width
DW, 16, memory data width
MAX_WAIT, 15, pending-cycle count at which aux is flagged starved (range 1..255)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
cpu_cmd  in  2  CPU memory command: 00 NONE, 01 READ, 10 WRITE, 11 treated as NONE
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  mem_rdata passed through combinationally
aux_req  in  1  aux request strobe; sampled only when aux_busy=0
aux_we  in  1  1=write, 0=read
aux_addr  in  AW  aux address
aux_wdata  in  DW  aux write data
aux_busy  out  1  request latched and not yet acked
aux_ack  out  1  one-cycle completion pulse
aux_rdata  out  DW  registered read data; valid while aux_ack=1 and held afterwards
aux_starved  out  1  wait counter has reached MAX_WAIT
mem_cmd  out  2  to memory
mem_addr  out  AW  to memory
mem_wdata  out  DW  to memory
mem_rdata  in  DW  from memory; asynchronous read, valid in the same cycle as mem_cmd=READ

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - aux_busy, aux_ack, aux_starved = 0.
  - aux_rdata, latched address/data/we and wait_cnt = 0.
  - A request in flight is dropped and never acked; the requester must re-issue it.
- States: IDLE, PEND, ACK.
- IDLE:
  - aux_req=1 at a clock edge latches aux_we, aux_addr and aux_wdata, then moves to PEND.
  - aux_busy=1 from the next cycle.
- PEND:
  - If cpu_cmd is READ or WRITE, the CPU owns the port: mem_* = cpu_*, state stays PEND, and wait_cnt increments, saturating at 255.
  - If cpu_cmd is NONE, aux owns the port: mem_cmd = WRITE or READ per the latched we, and mem_addr/mem_wdata come from the latch.
  - On that edge, a read captures mem_rdata into aux_rdata. The state moves to ACK.
- ACK:
  - aux_ack=1 for exactly one cycle and aux_busy=1.
  - Next state IDLE; wait_cnt clears.
  - The port belongs to the CPU in this cycle.
- Default mux: whenever aux does not own the port, mem_* = cpu_* and cmd 11 maps to NONE.
- Latency:
  - With the CPU idle, aux_ack rises 2 cycles after the edge that sampled aux_req.
  - Minimum request-to-request spacing is 3 cycles. aux_req seen in the ACK cycle is ignored.
- aux_starved = (wait_cnt >= MAX_WAIT), registered. It clears with wait_cnt.
- Aux write to an address the CPU writes in the same cycle cannot occur, since grants are exclusive.
- aux_* inputs may change while busy; only the latched values are used.

Optional Feature:
- Macro ARB_FORCE_GRANT_EN.
- Enabled:
  - Adds output cpu_stall (1 bit).
  - In PEND with wait_cnt >= MAX_WAIT, aux owns the port even if cpu_cmd is not NONE. cpu_stall=1 in that cycle and the CPU command is not issued to memory.
  - cpu_stall resets to 0 and is 0 in every other cycle.
- Disabled:
  - cpu_stall port is absent.
  - The CPU always wins; aux may starve indefinitely and is only flagged via aux_starved.

Test Plan:
- CPU idle, aux read of addr 0x05 holding 0xBEEF, request pulsed at edge t0 -> mem_cmd=01 and mem_addr=0x05 in cycle t0+1; aux_ack=1 with aux_rdata=0xBEEF in cycle t0+2; aux_busy cleared in cycle t0+3.
- Aux write 0x1234 to 0x10 while the CPU issues READs for 4 cycles and then NONE -> memory sees 4 CPU reads, then exactly one WRITE to 0x10, then aux_ack. A readback of 0x10 returns 0x1234.
- MAX_WAIT=3, aux pending while the CPU is busy 5 cycles -> aux_starved rises after 3 busy cycles and clears after aux_ack. With ARB_FORCE_GRANT_EN, aux is granted in the 4th busy cycle with cpu_stall=1 for one cycle.
- Reset asserted mid-PEND (asynchronously, between edges) -> outputs go to 0 immediately. No aux_ack ever appears, and mem_* follows cpu_* after release.
- aux_req held high continuously with the CPU idle -> one ack every 3 cycles, each serving the latched address. cpu_cmd=11 -> mem_cmd=00.
